// File: rtl/instr_loader.sv
// Boot loader: encodes compact RV32I descriptors into instruction memory, holding the core in reset until done.
// Optional: define LOADER_NOP_PAD_EN to fill unwritten memory with NOPs before releasing the core.
module instr_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};
`ifdef LOADER_NOP_PAD_EN
  localparam logic [31:0] NOP = 32'h0000_0013;
`endif

  localparam logic [3:0] OP_LW = 4'd0, OP_SW = 4'd1, OP_ADDI = 4'd2, OP_ADD = 4'd3,
                         OP_SUB = 4'd4, OP_AND = 4'd5, OP_OR = 4'd6, OP_SLT = 4'd7,
                         OP_LUI = 4'd8, OP_BEQ = 4'd9, OP_BNE = 4'd10, OP_JAL = 4'd11,
                         OP_JALR = 4'd12;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR, S_PAD} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;

  logic        i_ok, b_ok, j_ok, u_ok;
  logic        enc_ok;
  logic [31:0] enc_word;
  logic [31:0] imm;

  assign imm = in_imm;

  // Range checks: the bits above each format's sign bit must all match it.
  assign i_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign b_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign j_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
  assign u_ok = ~(|imm[11:0]);

  always_comb begin
    enc_ok   = 1'b1;
    enc_word = 32'h0;
    case (in_op)
      OP_LW:   begin enc_ok = i_ok; enc_word = {imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011}; end
      OP_SW:   begin enc_ok = i_ok; enc_word = {imm[11:5], in_rs2, in_rs1, 3'b010, imm[4:0], 7'b0100011}; end
      OP_ADDI: begin enc_ok = i_ok; enc_word = {imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011}; end
      OP_ADD:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      OP_SUB:  enc_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      OP_AND:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, 7'b0110011};
      OP_OR:   enc_word = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, 7'b0110011};
      OP_SLT:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b010, in_rd, 7'b0110011};
      OP_LUI:  begin enc_ok = u_ok; enc_word = {imm[31:12], in_rd, 7'b0110111}; end
      OP_BEQ:  begin
        enc_ok   = b_ok;
        enc_word = {imm[12], imm[10:5], in_rs2, in_rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      end
      OP_BNE:  begin
        enc_ok   = b_ok;
        enc_word = {imm[12], imm[10:5], in_rs2, in_rs1, 3'b001, imm[4:1], imm[11], 7'b1100011};
      end
      OP_JAL:  begin
        enc_ok   = j_ok;
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], in_rd, 7'b1101111};
      end
      OP_JALR: begin enc_ok = i_ok; enc_word = {imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111}; end
      default: enc_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (count_q == DEPTH || !enc_ok) begin
            state_d = S_ERROR;
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = count_q[ADDR_W-1:0];
            mem_wdata_d = enc_word;
            count_d     = count_q + ONE;
            if (in_last) begin
`ifdef LOADER_NOP_PAD_EN
              state_d = (count_q + ONE == DEPTH) ? S_DONE : S_PAD;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end
`ifdef LOADER_NOP_PAD_EN
      S_PAD: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = count_q[ADDR_W-1:0];
        mem_wdata_d = NOP;
        count_d     = count_q + ONE;
        if (count_q + ONE == DEPTH) state_d = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // DONE is entered together with the final write; hold the core until that write has retired.
  assign done      = (state_q == S_DONE) & ~mem_we_q;
  assign cpu_rst_n = done;
  assign err       = (state_q == S_ERROR);
  assign in_ready  = (state_q == S_LOAD);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: descriptor table plus hand-written multi-cycle sequences, writes checked by scoreboard.
module tb_instr_loader;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0, v0 = 1'b0, v1 = 1'b0;
  logic [3:0]  op = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;
  logic        last = 1'b0;

  logic        rdy0, we0, crst0, done0, err0;
  logic [7:0]  addr0;
  logic [31:0] wd0;
  logic [8:0]  cnt0;
  logic        rdy1, we1, crst1, done1, err1;
  logic [1:0]  addr1;
  logic [31:0] wd1;
  logic [2:0]  cnt1;

  instr_loader #(.ADDR_W(8)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start0), .in_valid(v0), .in_ready(rdy0),
    .in_op(op), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm), .in_last(last),
    .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0), .cpu_rst_n(crst0),
    .done(done0), .err(err0), .count(cnt0));

  instr_loader #(.ADDR_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(v1), .in_ready(rdy1),
    .in_op(op), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm), .in_last(last),
    .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1), .cpu_rst_n(crst1),
    .done(done1), .err(err1), .count(cnt1));

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] a; logic [31:0] d; } wr_t;
  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        ok;
    logic [31:0] word;
  } vec_t;

  wr_t  q0[$], q1[$];
  vec_t tab[20];
  int   total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input bit sel);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic beat(input bit sel, input logic [3:0] o, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im, input logic l);
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; last = l;
    if (sel) v1 = 1'b1; else v0 = 1'b1;
    chk("beat_ready", sel ? rdy1 : rdy0, 1'b1);
    tick();
    v0 = 1'b0; v1 = 1'b0; last = 1'b0;
  endtask

  task automatic chk_reset(input string nm);
    chk(nm, {rdy0, we0, addr0, wd0, crst0, done0, err0, cnt0}, 64'h0);
    chk({nm, "_s"}, {rdy1, we1, addr1, wd1, crst1, done1, err1, cnt1}, 64'h0);
  endtask

  initial begin
    tab = '{
      '{4'd0,  5'd2, 5'd3, 5'd0, 32'hFFFF_FFFC, 1'b1, 32'hFFC1_A103},  // LW -4
      '{4'd2,  5'd1, 5'd1, 5'd0, 32'h0000_07FF, 1'b1, 32'h7FF0_8093},  // ADDI max
      '{4'd2,  5'd1, 5'd1, 5'd0, 32'h0000_0800, 1'b0, 32'h0},
      '{4'd2,  5'd0, 5'd0, 5'd7, 32'hFFFF_F800, 1'b1, 32'h8000_0013},  // ADDI min
      '{4'd3,  5'd3, 5'd1, 5'd2, 32'h0000_0055, 1'b1, 32'h0020_81B3},
      '{4'd5,  5'd4, 5'd5, 5'd6, 32'h0,         1'b1, 32'h0062_F233},
      '{4'd6,  5'd4, 5'd5, 5'd6, 32'h0,         1'b1, 32'h0062_E233},
      '{4'd7,  5'd4, 5'd5, 5'd6, 32'h0,         1'b1, 32'h0062_A233},
      '{4'd8,  5'd5, 5'd3, 5'd4, 32'h1234_5000, 1'b1, 32'h1234_52B7},
      '{4'd8,  5'd5, 5'd0, 5'd0, 32'h1234_5001, 1'b0, 32'h0},
      '{4'd10, 5'd9, 5'd1, 5'd2, 32'h0000_0FFE, 1'b1, 32'h7E20_9FE3},  // BNE max
      '{4'd9,  5'd0, 5'd1, 5'd2, 32'h0000_0003, 1'b0, 32'h0},
      '{4'd9,  5'd0, 5'd1, 5'd2, 32'h0000_1000, 1'b0, 32'h0},
      '{4'd12, 5'd1, 5'd2, 5'd0, 32'h0000_0010, 1'b1, 32'h0101_00E7},
      '{4'd11, 5'd0, 5'd7, 5'd0, 32'hFFF0_0000, 1'b1, 32'h8000_006F},  // JAL min
      '{4'd11, 5'd0, 5'd0, 5'd0, 32'h0010_0000, 1'b0, 32'h0},
      '{4'd14, 5'd1, 5'd1, 5'd1, 32'h0,         1'b0, 32'h0},
      '{4'd13, 5'd1, 5'd1, 5'd1, 32'h0,         1'b0, 32'h0},
      '{4'd1,  5'd5, 5'd3, 5'd4, 32'hFFFF_FFFF, 1'b1, 32'hFE41_AFA3},  // SW -1
      '{4'd2,  5'd1, 5'd1, 5'd0, 32'hFFFF_F7FF, 1'b0, 32'h0}
    };

    fork
      begin : monitor
        wr_t e;
        forever begin
          @(negedge clk);
          if (we0) begin
            if (q0.size() == 0) chk("wr0_unexpected", we0, 1'b0);
            else begin e = q0.pop_front(); chk("wr0", {addr0, wd0}, {e.a, e.d}); end
          end
          if (we1) begin
            if (q1.size() == 0) chk("wr1_unexpected", we1, 1'b0);
            else begin e = q1.pop_front(); chk("wr1", {6'b0, addr1, wd1}, {e.a, e.d}); end
          end
        end
      end
      begin : watchdog
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
      end
    join_none

    #12;
    chk_reset("reset_values");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Mixed program, with a start pulse mid-load that must be ignored.
    go(0);
    q0.push_back('{8'd0, 32'h0050_0093});
    q0.push_back('{8'd1, 32'h4020_81B3});
    q0.push_back('{8'd2, 32'h0020_A423});
    q0.push_back('{8'd3, 32'hFE20_8EE3});
    q0.push_back('{8'd4, 32'h0080_00EF});
    beat(0, 4'd2,  5'd1, 5'd0, 5'd9, 32'd5, 1'b0);
    beat(0, 4'd4,  5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    start0 = 1'b1;
    beat(0, 4'd1,  5'd6, 5'd1, 5'd2, 32'd8, 1'b0);
    start0 = 1'b0;
    beat(0, 4'd9,  5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0);
    beat(0, 4'd11, 5'd1, 5'd4, 5'd0, 32'd8, 1'b1);
    chk("mix_ready_low", rdy0, 1'b0);
    chk("mix_done_early", {done0, crst0}, 2'b00);
    tick();
    chk("mix_done", {done0, crst0, err0}, 3'b110);
    chk("mix_count", cnt0, 9'd5);

    foreach (tab[i]) begin
      go(0);
      if (tab[i].ok) q0.push_back('{8'd0, tab[i].word});
      beat(0, tab[i].op, tab[i].rd, tab[i].rs1, tab[i].rs2, tab[i].imm, 1'b1);
      chk($sformatf("vec%0d_ready", i), rdy0, 1'b0);
      if (tab[i].ok) begin
        tick();
        chk($sformatf("vec%0d_done", i), {done0, crst0, err0}, 3'b110);
        chk($sformatf("vec%0d_count", i), cnt0, 9'd1);
      end else begin
        chk($sformatf("vec%0d_err", i), {err0, done0, crst0}, 3'b100);
        chk($sformatf("vec%0d_count", i), cnt0, 9'd0);
        tick();
        chk($sformatf("vec%0d_err_sticky", i), err0, 1'b1);
      end
    end

    // Overflow on the 4-word instance.
    go(1);
    for (int k = 0; k < 4; k++) q1.push_back('{k[7:0], 32'h0050_0093});
    for (int k = 0; k < 5; k++) beat(1, 4'd2, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    chk("ovf_err", {err1, rdy1, crst1}, 3'b100);
    chk("ovf_count", cnt1, 3'd4);

    // Reset asserted while a write is on the bus.
    go(0);
    beat(0, 4'd2, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    chk("midrst_write_live", we0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset("midrst_values");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

`ifdef LOADER_NOP_PAD_EN
    go(1);
    q1.push_back('{8'd0, 32'h0020_81B3});
    q1.push_back('{8'd1, 32'h0000_0013});
    q1.push_back('{8'd2, 32'h0000_0013});
    q1.push_back('{8'd3, 32'h0000_0013});
    beat(1, 4'd3, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
    chk("pad_hold", {rdy1, crst1, done1}, 3'b000);
    for (int n = 0; n < 10 && !done1; n++) tick();
    chk("pad_done", {done1, crst1}, 2'b11);
    chk("pad_count", cnt1, 3'd4);
    chk("pad_all_written", q1.size(), 0);
`endif

    tick();
    tick();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

- Boot-time program loader that feeds the single-cycle RV32I core.
- Accepts a stream of compact instruction descriptors (mnemonic, rd, rs1, rs2, immediate) over a valid/ready handshake.
- Encodes each descriptor into a 32-bit RV32I word for exactly the subset the control decoder supports, and writes the words sequentially into instruction memory from address 0.
- Holds the core in reset while loading and releases it once the program is complete.

## Interface
- `ADDR_W`, default 8 — instruction-memory word-address width; capacity `DEPTH = 2**ADDR_W` words.
- `clk` input 1 — single clock, rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `start` input 1 — begin a load; sampled in IDLE, DONE and ERROR only.
- `in_valid` input 1 — descriptor valid.
- `in_ready` output 1 — loader can accept a descriptor.
- `in_op` input 4 — mnemonic: 0 LW, 1 SW, 2 ADDI, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 SLT, 8 LUI, 9 BEQ, 10 BNE, 11 JAL, 12 JALR; 13–15 illegal.
- `in_rd`, `in_rs1`, `in_rs2` input 5 each — register fields.
- `in_imm` input 32 — signed byte-offset immediate (LUI: full 32-bit value).
- `in_last` input 1 — descriptor is the final instruction.
- `mem_we` output 1 — instruction-memory write strobe.
- `mem_addr` output ADDR_W — word address.
- `mem_wdata` output 32 — encoded instruction.
- `cpu_rst_n` output 1 — core reset, active-low.
- `done` output 1 — program loaded, core running.
- `err` output 1 — sticky error flag; cleared by `start`.
- `count` output ADDR_W+1 — words written in the current load.

## Operation
**States:** IDLE, LOAD, DONE, ERROR.
- **IDLE:** `in_ready=0`, `cpu_rst_n=0`. On `start`, go to LOAD with `count=0`.
- **LOAD:** `in_ready=1`, `cpu_rst_n=0`. A beat is accepted when `in_valid && in_ready`. The accepted beat is range-checked and encoded.
  - **Legal beat:** written at `mem_addr=count`, then `count` increments.
  - **`in_last` on a legal beat:** go to DONE.
  - **Illegal op or out-of-range immediate:** go to ERROR, no write.
  - **Overflow:** a beat accepted while `count==DEPTH` goes to ERROR, no write.
- **DONE:** `done=1`, `cpu_rst_n=1`, `in_ready=0`. `start` returns to LOAD (count cleared, core re-held).
- **ERROR:** `err=1`, `cpu_rst_n=0`, `in_ready=0`. `start` returns to LOAD and clears `err`.
- **`start` while in LOAD:** ignored.

**Encodings** (`in_rd` / `in_rs1` / `in_rs2` placed at [11:7] / [19:15] / [24:20]):

| Mnemonic | Opcode | funct3 | funct7 |
|---|---|---|---|
| LW | 0000011 | 010 | — |
| SW | 0100011 | 010 | — |
| ADDI | 0010011 | 000 | — |
| ADD | 0110011 | 000 | 0000000 |
| SUB | 0110011 | 000 | 0100000 |
| AND | 0110011 | 111 | 0000000 |
| OR | 0110011 | 110 | 0000000 |
| SLT | 0110011 | 010 | 0000000 |
| LUI | 0110111 | — | — |
| BEQ | 1100011 | 000 | — |
| BNE | 1100011 | 001 | — |
| JAL | 1101111 | — | — |
| JALR | 1100111 | 000 | — |

Fields not used by a format are ignored.

**Immediate legality:**

| Type | Mnemonics | Legal range |
|---|---|---|
| I, S | LW, ADDI, JALR, SW | −2048..2047 |
| B | BEQ, BNE | −4096..4094, even |
| J | JAL | −2^20..2^20−2, even |
| U | LUI | `in_imm[11:0]==0`; word uses `in_imm[31:12]` |

## Timing
- **Reset values:** state IDLE, `in_ready=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `cpu_rst_n=0`, `done=0`, `err=0`, `count=0`.
- **Write stage:** registered. A beat accepted at edge N drives `mem_we=1` with address/data during cycle N+1, for exactly one cycle per word.
- **Throughput:** one descriptor per cycle; `in_ready` has no internal stall in LOAD.
- **`in_ready` deassertion:** in the cycle after an `in_last` beat, error beat or overflow beat.
- **Core release:** `cpu_rst_n` and `done` rise in the same cycle as the final `mem_we` pulse is registered out, plus one cycle. The core never runs before its last word is written.
- **Error and overflow:** `err` rises the cycle after the offending beat.
- **Count:** `count` reflects writes issued and saturates at DEPTH.
- **Reset mid-load:** immediate return to reset values. Any in-flight write is dropped, and `mem_we` is forced low asynchronously.

## Configuration
- **Macro:** `LOADER_NOP_PAD_EN`.
- **Defined:**
  - After a legal `in_last` beat the FSM enters an extra PAD state instead of DONE.
  - PAD writes NOP `0x00000013` (ADDI x0,x0,0) to every remaining address, one per cycle, until `count==DEPTH`, then goes to DONE.
  - `in_ready=0` and `cpu_rst_n=0` during PAD.
  - If `in_last` fills the memory exactly, PAD is skipped.
- **Undefined:** no PAD state; unwritten memory is untouched.

## Test plan
- **Mixed program:** `start`, then ADDI rd1 rs1=0 imm5 / SUB rd3 rs1=1 rs2=2 / SW rs1=1 rs2=2 imm8 / BEQ rs1=1 rs2=2 imm−4 / JAL rd1 imm8 (last) → writes `0x00500093`, `0x402081B3`, `0x0020A423`, `0xFE208EE3`, `0x008000EF` at addresses 0–4. `done` and `cpu_rst_n` high one cycle after the last write; `count=5`.
- **Range errors:** BEQ imm3 → `err=1` next cycle, no `mem_we`, `in_ready=0`. `start` then clears `err` and LOAD restarts at address 0.
- **Illegal op:** `in_op=14` → ERROR, no write. LUI with `in_imm=0x12345001` → ERROR. LUI `0x12345000` rd5 → `0x123452B7`.
- **Overflow** (ADDR_W=2): five ADDI beats, no `in_last` → four writes at addresses 0–3, fifth beat → ERROR, `count=4`.
- **Reset mid-load:** `rst_n` low during a write cycle → `mem_we` low immediately, all outputs at reset values, `cpu_rst_n=0`.
- **Pad build** (ADDR_W=2, `LOADER_NOP_PAD_EN`): a single ADD (last) → word at address 0, then `0x00000013` at addresses 1–3 on consecutive cycles, then DONE.
